pcm_frame_scheduler: RTL and testbench
======================================

PCM_FRAME_SCHEDULER -- requirements
Module: pcm_frame_scheduler

Interface
REQ-001 SHALL have parameter NCHAN, default 16: channels per PCM frame.
REQ-002 SHALL have parameter HDR_LEN, default 14: header bytes reserved at the start of each bank.
REQ-003 SHALL have parameter PKT_FRAMES, default 16: PCM frames per packet.
REQ-004 SHALL have parameter WD_LIMIT, default 1023: filter-busy timeout in cycles.
REQ-005 SHALL have port clk, in, 1: the single clock, rising edge.
REQ-006 SHALL have port rst_n, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pcm_stb, in, 1: one-cycle pulse marking a new PCM frame.
REQ-008 SHALL have port cic_sel, out, 4: channel index selecting the CIC integrator output.
REQ-009 SHALL have port flt_stb, out, 1: start pulse to the shared audio filter.
REQ-010 SHALL have port flt_addr, out, 10: filter state base address, chan*8.
REQ-011 SHALL have port flt_busy, in, 1: shared filter running.
REQ-012 SHALL have port flt_out, in, 16: filter PCM result.
REQ-013 SHALL have port wr_en, out, 1: packet BRAM write enable.
REQ-014 SHALL have port wr_addr, out, 11: packet BRAM write address, formed as {bank, ptr[9:0]}.
REQ-015 SHALL have port wr_data, out, 8: packet BRAM write byte.
REQ-016 SHALL have port tx_start, out, 1: one-cycle pulse that starts Ethernet transmit.
REQ-017 SHALL have port tx_bank, out, 1: bank the transmitter reads.
REQ-018 SHALL have port tx_busy, in, 1: Ethernet transmitter active.
REQ-019 SHALL have port drop_cnt, out, 8: packets dropped because tx_busy was high, saturating.
REQ-020 SHALL have port miss_cnt, out, 8: pcm_stb pulses ignored while not in IDLE, saturating.
REQ-021 SHALL have port flt_err, out, 1: sticky flag, set on filter timeout.

Function
REQ-022 SHALL implement the states IDLE, LOAD, STROBE, WAIT, WR_LO, WR_HI, NEXT, CHECK.
REQ-023 In IDLE, pcm_stb SHALL set chan=0 and move the FSM to LOAD; without pcm_stb the FSM SHALL stay in IDLE.
REQ-024 LOAD SHALL register flt_addr=chan*8, and cic_sel SHALL equal chan at all times; LOAD SHALL be followed by STROBE.
REQ-025 STROBE SHALL drive flt_stb=1 for exactly one cycle, then enter WAIT with the watchdog cleared.
REQ-026 WAIT SHALL ignore flt_busy during its first cycle, then advance to WR_LO on the first cycle with flt_busy=0.
REQ-027 If WAIT lasts WD_LIMIT cycles, the FSM SHALL set flt_err, rewind ptr by 2*chan, and return to IDLE; the partial frame is discarded.
REQ-028 WR_LO SHALL drive wr_en=1, wr_addr={fill_bank,ptr}, wr_data=flt_out[7:0], and increment ptr.
REQ-029 WR_HI SHALL do the same with flt_out[15:8]; each channel therefore produces bytes in little-endian order.
REQ-030 NEXT SHALL increment chan, with wr_en=0; it SHALL go to CHECK when chan==NCHAN-1, else to LOAD.
REQ-031 In CHECK, the packet SHALL count as full when ptr==HDR_LEN+2*NCHAN*PKT_FRAMES (526 by default).
REQ-032 Full with tx_busy=0: tx_start=1 for one cycle, tx_bank=fill_bank, fill_bank toggles, ptr=HDR_LEN.
REQ-033 Full with tx_busy=1: drop_cnt increments, saturating at 255; ptr=HDR_LEN; fill_bank and tx_bank are unchanged.
REQ-034 Not full: the FSM SHALL return to IDLE without side effects; every CHECK exit SHALL go to IDLE.
REQ-035 pcm_stb in any state other than IDLE SHALL increment miss_cnt, saturating at 255, and SHALL be otherwise ignored.
REQ-036 The scheduler SHALL never write to tx_bank while tx_busy=1; the fill bank and the transmit bank SHALL always differ after the first handoff.
REQ-037 Latency from pcm_stb to the first wr_en SHALL be 4 cycles plus the filter busy time.

Reset
REQ-038 While rst_n=0, the block SHALL be in IDLE with chan=0, ptr=HDR_LEN, fill_bank=0, and tx_bank=1.
REQ-039 While rst_n=0, all of flt_stb, wr_en, tx_start, flt_err, drop_cnt, miss_cnt, flt_addr, wr_addr, and wr_data SHALL be 0.
REQ-040 Reset asserted mid-frame SHALL abandon the frame immediately, and no further write SHALL occur after release until a new pcm_stb.

Structure
REQ-041 Package pcm_sched_pkg SHALL hold NCHAN, HDR_LEN, PKT_FRAMES, PKT_END (=526), and the state encoding.
REQ-042 The saturating 8-bit counter SHALL be one sub-module, sat_cnt8, instantiated twice, for drop_cnt and miss_cnt.

Verification
REQ-043 Filter model with 3-cycle busy and flt_out=16'hA5C3+chan; one pcm_stb -> 32 writes at 14..45, bytes C3,A5,C4,A5,... in bank 0.
REQ-044 16 pcm_stb, tx_busy=0 -> a single tx_start after the 16th frame with tx_bank=0; the next frame writes bank 1 starting at addr 14.
REQ-045 Hold tx_busy=1 across the second packet completion -> drop_cnt=1, no tx_start, and bank 1 is refilled starting at addr 14.
REQ-046 pcm_stb repeated 5 cycles after the first pcm_stb -> miss_cnt=1 and frame output identical to the single-stb case.
REQ-047 flt_busy stuck at 1 on chan 5 -> flt_err=1 after 1023 cycles, ptr rewound by 10; the next frame overwrites the same addresses.
REQ-048 rst_n pulsed low during WR_HI of chan 7 -> all outputs 0 at once; after release no wr_en until pcm_stb, and the first write is at addr 14 of bank 0.

Source files
------------

// File: rtl/pcm_sched_pkg.sv
// Shared constants and FSM state encoding for the PCM frame scheduler.
package pcm_sched_pkg;

  localparam int unsigned NCHAN      = 16;
  localparam int unsigned HDR_LEN    = 14;
  localparam int unsigned PKT_FRAMES = 16;
  localparam int unsigned PKT_END    = HDR_LEN + 2 * NCHAN * PKT_FRAMES;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] S_LOAD   = 3'd1;
  localparam logic [ST_W-1:0] S_STROBE = 3'd2;
  localparam logic [ST_W-1:0] S_WAIT   = 3'd3;
  localparam logic [ST_W-1:0] S_WR_LO  = 3'd4;
  localparam logic [ST_W-1:0] S_WR_HI  = 3'd5;
  localparam logic [ST_W-1:0] S_NEXT   = 3'd6;
  localparam logic [ST_W-1:0] S_CHECK  = 3'd7;

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit event counter that sticks at 255.
module sat_cnt8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  output logic [7:0] o_cnt
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pcm_frame_scheduler.sv
// Walks every channel of a PCM frame through the shared filter, packs the
// results into a double-banked packet buffer and hands full banks to Ethernet.
module pcm_frame_scheduler #(
  parameter int unsigned NCHAN      = pcm_sched_pkg::NCHAN,
  parameter int unsigned HDR_LEN    = pcm_sched_pkg::HDR_LEN,
  parameter int unsigned PKT_FRAMES = pcm_sched_pkg::PKT_FRAMES,
  parameter int unsigned WD_LIMIT   = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcm_stb,
  output logic [3:0]  cic_sel,
  output logic        flt_stb,
  output logic [9:0]  flt_addr,
  input  logic        flt_busy,
  input  logic [15:0] flt_out,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        tx_start,
  output logic        tx_bank,
  input  logic        tx_busy,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  miss_cnt,
  output logic        flt_err
);

  import pcm_sched_pkg::ST_W;
  import pcm_sched_pkg::S_IDLE;
  import pcm_sched_pkg::S_LOAD;
  import pcm_sched_pkg::S_STROBE;
  import pcm_sched_pkg::S_WAIT;
  import pcm_sched_pkg::S_WR_LO;
  import pcm_sched_pkg::S_WR_HI;
  import pcm_sched_pkg::S_NEXT;
  import pcm_sched_pkg::S_CHECK;

  localparam int unsigned PTR_W = 10;
  localparam int unsigned WD_W  = $clog2(WD_LIMIT + 1);
  localparam logic [PTR_W-1:0] PTR_HDR   = PTR_W'(HDR_LEN);
  localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(HDR_LEN + 2 * NCHAN * PKT_FRAMES);
  localparam logic [3:0]       CHAN_LAST = 4'(NCHAN - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WD_LIMIT - 1);

  logic [ST_W-1:0]  r_state,     w_state_nxt;
  logic [3:0]       r_chan,      w_chan_nxt;
  logic [PTR_W-1:0] r_ptr,       w_ptr_nxt;
  logic             r_fill_bank, w_fill_bank_nxt;
  logic             r_tx_bank,   w_tx_bank_nxt;
  logic [WD_W-1:0]  r_wd,        w_wd_nxt;
  logic             r_flt_stb,   w_flt_stb_nxt;
  logic [9:0]       r_flt_addr,  w_flt_addr_nxt;
  logic             r_wr_en,     w_wr_en_nxt;
  logic [10:0]      r_wr_addr,   w_wr_addr_nxt;
  logic [7:0]       r_wr_data,   w_wr_data_nxt;
  logic             r_tx_start,  w_tx_start_nxt;
  logic             r_flt_err,   w_flt_err_nxt;
  logic             w_drop_inc;
  logic             w_miss_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_chan      <= '0;
      r_ptr       <= PTR_HDR;
      r_fill_bank <= 1'b0;
      r_tx_bank   <= 1'b1;
      r_wd        <= '0;
      r_flt_stb   <= 1'b0;
      r_flt_addr  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_tx_start  <= 1'b0;
      r_flt_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_chan      <= w_chan_nxt;
      r_ptr       <= w_ptr_nxt;
      r_fill_bank <= w_fill_bank_nxt;
      r_tx_bank   <= w_tx_bank_nxt;
      r_wd        <= w_wd_nxt;
      r_flt_stb   <= w_flt_stb_nxt;
      r_flt_addr  <= w_flt_addr_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_flt_err   <= w_flt_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_chan_nxt      = r_chan;
    w_ptr_nxt       = r_ptr;
    w_fill_bank_nxt = r_fill_bank;
    w_tx_bank_nxt   = r_tx_bank;
    w_wd_nxt        = r_wd;
    w_flt_addr_nxt  = r_flt_addr;
    w_flt_err_nxt   = r_flt_err;
    w_flt_stb_nxt   = 1'b0;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = '0;
    w_wr_data_nxt   = '0;
    w_tx_start_nxt  = 1'b0;
    w_drop_inc      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (pcm_stb) begin
          w_chan_nxt  = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_flt_addr_nxt = {3'b000, r_chan, 3'b000};
        w_state_nxt    = S_STROBE;
      end
      S_STROBE: begin
        w_wd_nxt    = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle is blind: the filter may not have raised busy yet.
        w_wd_nxt = r_wd + WD_W'(1);
        if ((r_wd != '0) && !flt_busy) begin
          w_state_nxt = S_WR_LO;
        end else if (r_wd == WD_LAST) begin
          w_flt_err_nxt = 1'b1;
          w_ptr_nxt     = r_ptr - PTR_W'({r_chan, 1'b0});
          w_state_nxt   = S_IDLE;
        end
      end
      S_WR_LO: w_state_nxt = S_WR_HI;
      S_WR_HI: w_state_nxt = S_NEXT;
      S_NEXT: begin
        w_chan_nxt  = r_chan + 4'd1;
        w_state_nxt = (r_chan == CHAN_LAST) ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
        if (r_ptr == PTR_FULL) begin
          w_ptr_nxt = PTR_HDR;
          if (tx_busy) begin
            w_drop_inc = 1'b1;
          end else begin
            w_tx_start_nxt  = 1'b1;
            w_tx_bank_nxt   = r_fill_bank;
            w_fill_bank_nxt = ~r_fill_bank;
          end
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Strobe and write outputs are registered so they line up with the state entered.
    w_flt_stb_nxt = (w_state_nxt == S_STROBE);
    if ((w_state_nxt == S_WR_LO) || (w_state_nxt == S_WR_HI)) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_addr_nxt = {r_fill_bank, r_ptr};
      w_wr_data_nxt = (w_state_nxt == S_WR_LO) ? flt_out[7:0] : flt_out[15:8];
      w_ptr_nxt     = r_ptr + PTR_W'(1);
    end
  end

  assign w_miss_inc = pcm_stb && (r_state != S_IDLE);

  sat_cnt8 u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_drop_inc),
    .o_cnt (drop_cnt)
  );

  sat_cnt8 u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_miss_inc),
    .o_cnt (miss_cnt)
  );

  assign cic_sel  = r_chan;
  assign flt_stb  = r_flt_stb;
  assign flt_addr = r_flt_addr;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign tx_start = r_tx_start;
  assign tx_bank  = r_tx_bank;
  assign flt_err  = r_flt_err;

endmodule

// File: tb/tb_pcm_frame_scheduler.sv
// Directed bench for pcm_frame_scheduler with a 3-cycle filter model and a write log.
module tb_pcm_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcm_stb = 1'b0;
  logic        flt_busy = 1'b0;
  logic [15:0] flt_out = 16'h0000;
  logic        tx_busy = 1'b0;
  logic [3:0]  cic_sel;
  logic        flt_stb;
  logic [9:0]  flt_addr;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        tx_start;
  logic        tx_bank;
  logic [7:0]  drop_cnt;
  logic [7:0]  miss_cnt;
  logic        flt_err;

  int errors = 0;
  int checks = 0;

  logic [10:0] wlog_addr[$];
  logic [7:0]  wlog_data[$];
  int          tx_cnt = 0;
  logic        tx_bank_seen = 1'b1;
  bit          stuck_en = 1'b0;
  bit          stuck_hold = 1'b0;
  int          busy_left = 0;

  always #5 clk = ~clk;

  pcm_frame_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pcm_stb  (pcm_stb),
    .cic_sel  (cic_sel),
    .flt_stb  (flt_stb),
    .flt_addr (flt_addr),
    .flt_busy (flt_busy),
    .flt_out  (flt_out),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .tx_start (tx_start),
    .tx_bank  (tx_bank),
    .tx_busy  (tx_busy),
    .drop_cnt (drop_cnt),
    .miss_cnt (miss_cnt),
    .flt_err  (flt_err)
  );

  // Filter model: busy for 3 cycles after a start, or forever on chan 5 when stuck.
  always @(negedge clk) begin
    if (!rst_n) begin
      flt_busy   = 1'b0;
      busy_left  = 0;
      stuck_hold = 1'b0;
    end else if (flt_stb) begin
      flt_out  = 16'hA5C3 + 16'(cic_sel);
      flt_busy = 1'b1;
      if (stuck_en && (cic_sel == 4'd5)) stuck_hold = 1'b1;
      else busy_left = 3;
    end else if (stuck_hold) begin
      if (!stuck_en) begin
        stuck_hold = 1'b0;
        flt_busy   = 1'b0;
      end
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) flt_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (wr_en) begin
      wlog_addr.push_back(wr_addr);
      wlog_data.push_back(wr_data);
    end
    if (tx_start) begin
      tx_cnt       = tx_cnt + 1;
      tx_bank_seen = tx_bank;
    end
  end

  task automatic run_frame(input int rep, output int n0, output bit ok);
    n0 = wlog_addr.size();
    @(negedge clk); pcm_stb = 1'b1;
    @(negedge clk); pcm_stb = 1'b0;
    if (rep > 0) begin
      repeat (rep - 1) @(negedge clk);
      pcm_stb = 1'b1;
      @(negedge clk); pcm_stb = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (wlog_addr.size() >= n0 + 32) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({flt_stb, wr_en, tx_start, flt_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 0000", {flt_stb, wr_en, tx_start, flt_err});
    end
    checks++;
    if ({drop_cnt, miss_cnt} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_counters: got drop=%0d miss=%0d expected 0", drop_cnt, miss_cnt);
    end
    checks++;
    if ({flt_addr, wr_addr, wr_data} !== 29'h0) begin
      errors++;
      $display("FAIL reset_buses: got flt_addr=%h wr_addr=%h wr_data=%h expected 0", flt_addr, wr_addr, wr_data);
    end
    checks++;
    if (tx_bank !== 1'b1 || cic_sel !== 4'd0) begin
      errors++;
      $display("FAIL reset_bank_chan: got tx_bank=%b cic_sel=%0d expected 1,0", tx_bank, cic_sel);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int n0; bit ok;
    run_frame(0, n0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: got %0d writes expected 32", wlog_addr.size() - n0); end
    for (int i = 0; i < 32; i++) begin
      logic [10:0] ea; logic [7:0] ed;
      ea = 11'd14 + 11'(i);
      ed = (i % 2 == 0) ? 8'(8'hC3 + i / 2) : 8'hA5;
      checks++;
      if (wlog_addr[n0+i] !== ea || wlog_data[n0+i] !== ed) begin
        errors++;
        $display("FAIL single_wr%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, wlog_addr[n0+i], wlog_data[n0+i], ea, ed);
      end
    end
  endtask

  task automatic test_missed_stb();
    int n0; bit ok;
    run_frame(5, n0, ok);
    checks++;
    if (miss_cnt !== 8'd1 || !ok) begin
      errors++;
      $display("FAIL miss_cnt: got %0d (done=%0b) expected 1", miss_cnt, ok);
    end
    for (int i = 0; i < 32; i++) begin
      logic [10:0] ea; logic [7:0] ed;
      ea = 11'd46 + 11'(i);
      ed = (i % 2 == 0) ? 8'(8'hC3 + i / 2) : 8'hA5;
      checks++;
      if (wlog_addr[n0+i] !== ea || wlog_data[n0+i] !== ed) begin
        errors++;
        $display("FAIL miss_wr%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, wlog_addr[n0+i], wlog_data[n0+i], ea, ed);
      end
    end
  endtask

  task automatic test_packet_handoff();
    int n0; bit ok;
    for (int f = 3; f <= 15; f++) begin
      run_frame(0, n0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL handoff_frame%0d: got incomplete expected 32 writes", f); end
    end
    checks++;
    if (tx_cnt !== 0) begin errors++; $display("FAIL early_tx_start: got %0d expected 0", tx_cnt); end
    run_frame(0, n0, ok);
    checks++;
    if (tx_cnt !== 1 || tx_bank_seen !== 1'b0 || tx_bank !== 1'b0) begin
      errors++;
      $display("FAIL handoff_tx: got cnt=%0d bank_at_start=%b bank=%b expected 1,0,0", tx_cnt, tx_bank_seen, tx_bank);
    end
    run_frame(0, n0, ok);
    checks++;
    if (!ok || wlog_addr[n0] !== 11'd1038 || wlog_addr[n0+31] !== 11'd1069) begin
      errors++;
      $display("FAIL bank1_start: got first=%0d last=%0d expected 1038,1069", wlog_addr[n0], wlog_addr[n0+31]);
    end
  endtask

  task automatic test_drop();
    int n0; bit ok;
    for (int f = 18; f <= 31; f++) begin
      run_frame(0, n0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL drop_frame%0d: got incomplete expected 32 writes", f); end
    end
    tx_busy = 1'b1;
    run_frame(0, n0, ok);
    checks++;
    if (drop_cnt !== 8'd1 || tx_cnt !== 1 || tx_bank !== 1'b0) begin
      errors++;
      $display("FAIL drop: got drop=%0d tx_cnt=%0d tx_bank=%b expected 1,1,0", drop_cnt, tx_cnt, tx_bank);
    end
    tx_busy = 1'b0;
    run_frame(0, n0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL refill_done: got incomplete expected 32 writes"); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (wlog_addr[n0+i] !== 11'd1038 + 11'(i)) begin
        errors++;
        $display("FAIL refill_wr%0d: got addr=%0d expected %0d", i, wlog_addr[n0+i], 1038 + i);
      end
    end
  endtask

  task automatic test_watchdog();
    int n0; bit ok;
    stuck_en = 1'b1;
    n0 = wlog_addr.size();
    @(negedge clk); pcm_stb = 1'b1;
    @(negedge clk); pcm_stb = 1'b0;
    repeat (1000) @(negedge clk);
    checks++;
    if (flt_err !== 1'b0) begin errors++; $display("FAIL wd_early: got flt_err=%b expected 0", flt_err); end
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (flt_err === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wd_timeout: got flt_err=%b expected 1", flt_err); end
    checks++;
    if (wlog_addr.size() - n0 !== 10) begin
      errors++;
      $display("FAIL wd_partial: got %0d writes expected 10", wlog_addr.size() - n0);
    end
    stuck_en = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(0, n0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wd_refill_done: got incomplete expected 32 writes"); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (wlog_addr[n0+i] !== 11'd1070 + 11'(i)) begin
        errors++;
        $display("FAIL wd_rewind_wr%0d: got addr=%0d expected %0d", i, wlog_addr[n0+i], 1070 + i);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n0; int n1; bit ok; bit found;
    @(negedge clk); pcm_stb = 1'b1;
    @(negedge clk); pcm_stb = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (wr_en && cic_sel == 4'd7 && wr_data == 8'hA5) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_find: got no chan7 high write expected one"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({flt_stb, wr_en, tx_start, flt_err} !== 4'b0000 || {drop_cnt, miss_cnt} !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b drop=%0d miss=%0d expected 0", {flt_stb, wr_en, tx_start, flt_err}, drop_cnt, miss_cnt);
    end
    checks++;
    if ({flt_addr, wr_addr, wr_data} !== 29'h0 || tx_bank !== 1'b1 || cic_sel !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_buses: got wr_addr=%h wr_data=%h tx_bank=%b cic=%0d expected 0,0,1,0", wr_addr, wr_data, tx_bank, cic_sel);
    end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    n1 = wlog_addr.size();
    repeat (40) @(negedge clk);
    checks++;
    if (wlog_addr.size() !== n1) begin
      errors++;
      $display("FAIL mid_no_write: got %0d writes expected 0", wlog_addr.size() - n1);
    end
    run_frame(0, n0, ok);
    checks++;
    if (!ok || wlog_addr[n0] !== 11'd14 || wlog_addr[n0+31] !== 11'd45) begin
      errors++;
      $display("FAIL mid_restart: got first=%0d last=%0d expected 14,45", wlog_addr[n0], wlog_addr[n0+31]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_missed_stb();
    test_packet_handoff();
    test_drop();
    test_watchdog();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
